vmem_port_arbiter: RTL
======================

Name: vmem_port_arbiter

Overview:
- Shares one single-port, synchronous-read video memory between the VGA pixel fetch path and two pixel-write requesters.
- Requester 0 is the keyboard console; requester 1 is the debug/loader path.
- VGA reads have absolute priority. Writes are buffered in per-requester FIFOs and drained round-robin in cycles with no read.
- Sits between vga_ctrl's h_addr/v_addr/valid and the video memory array.

Parameters:
- AW, 19: memory address width; address is {h_addr[9:0], v_addr[8:0]}.
- DW, 24: pixel data width (RGB888).
- FIFO_DEPTH, 4: entries per write FIFO; power of two, minimum 2.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- vga_rd_en  input  1  read request this cycle (vga_ctrl valid).
- vga_rd_addr  input  AW  read address.
- vga_rd_data  output  DW  read data; equals mem_rdata.
- vga_rd_vld  output  1  vga_rd_data is valid this cycle.
- wr0_valid  input  1  requester 0 write request.
- wr0_addr  input  AW  requester 0 write address.
- wr0_data  input  DW  requester 0 write data.
- wr0_ready  output  1  requester 0 FIFO not full.
- wr1_valid / wr1_addr / wr1_data / wr1_ready: same as wr0_* for requester 1.
- mem_en  output  1  memory access enable (registered).
- mem_we  output  1  1 = write, 0 = read (registered).
- mem_addr  output  AW  memory address (registered).
- mem_wdata  output  DW  memory write data (registered).
- mem_rdata  input  DW  memory read data, one cycle after a mem_en read.

Behaviour:
- Reset (synchronous) sets: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, vga_rd_vld=0. Both FIFOs are emptied and pending writes are discarded. The round-robin pointer is set to 0.
- wrN_ready = !fullN, taken from registered count only. A push occurs on wrN_valid && wrN_ready.
- Push and pop on the same FIFO in the same cycle: both happen and the count is unchanged.
- A full FIFO does not accept a push even when a pop occurs in that cycle.
- Issue decision each cycle, registered onto the mem_* outputs at the next edge:
  - ISSUE_RD: vga_rd_en=1. Registers mem_en=1, we=0, addr=vga_rd_addr. Both FIFOs stall.
  - ISSUE_WR: vga_rd_en=0 and at least one FIFO non-empty. Grant goes to the FIFO selected by the round-robin pointer if it is non-empty, otherwise to the other FIFO. Registers we=1 with the head entry's addr/data and pops that FIFO the same cycle. The pointer then moves to the non-granted requester.
  - IDLE: otherwise. Registers mem_en=0, we=0; addr and wdata hold their previous values.
- Read latency is fixed at 2 cycles: vga_rd_en at cycle t gives mem_en at t+1 and vga_rd_vld=1 at t+2. vga_rd_vld is a 2-stage shift of accepted reads.
- Ordering:
  - Writes within one requester are committed in FIFO order.
  - Writes from different requesters are committed in grant order.
  - A read issued after a write to the same address is committed returns the new data.
- A write request arriving during a read burst is held in its FIFO. It is not lost while ready=1.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is log2(FIFO_DEPTH)+1 bits.
- Reset asserted mid-burst: vga_rd_vld drops on the next cycle, and any in-flight read data is not flagged valid.

Optional Feature:
- Macro: VMEM_ARB_STATS_EN.
- When defined, adds output wr_stall_cnt (16 bits). It counts cycles where at least one FIFO is non-empty and vga_rd_en=1.
- The counter saturates at 16'hFFFF and is cleared by rst.
- When the macro is undefined, the port and the counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then a single wr0 write (addr=0x00010, data=0xFF0000) with vga_rd_en=0. Expect mem_we=1, addr=0x00010, wdata=0xFF0000 two cycles after valid. Then read 0x00010 and expect vga_rd_vld with data 0xFF0000 two cycles after vga_rd_en.
- Hold vga_rd_en=1 for 10 cycles while pushing 4 writes on wr0. Expect wr0_ready=0 after the 4th push and no mem_we during the read burst. All 4 writes then commit in order in the 4 cycles after vga_rd_en falls.
- Both FIFOs each hold 2 entries (A0, A1 and B0, B1) with no reads. Expect commit order A0, B0, A1, B1.
- FIFO at count 3 of 4 with a simultaneous push and pop. Expect count to stay 3 and wr0_ready to stay 1. At count 4, wrN_valid=1 is not accepted.
- Assert rst while both FIFOs are non-empty and a read is in flight. Expect no further mem_we, vga_rd_vld=0 next cycle, and wr0_ready=wr1_ready=1 after reset.
- With VMEM_ARB_STATS_EN defined: 5 read cycles with FIFO non-empty, then 3 read cycles with FIFOs empty. Expect wr_stall_cnt=5.

Source files
------------

// File: rtl/vmem_port_arbiter.sv
// rtl/vmem_port_arbiter.sv - VGA-priority video memory port arbiter with two buffered write requesters
// Optional feature macro: VMEM_ARB_STATS_EN adds the 16-bit wr_stall_cnt output.
module vmem_port_arbiter #(
  parameter int AW         = 19,
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vga_rd_en,
  input  logic [AW-1:0] vga_rd_addr,
  output logic [DW-1:0] vga_rd_data,
  output logic          vga_rd_vld,
  input  logic          wr0_valid,
  input  logic [AW-1:0] wr0_addr,
  input  logic [DW-1:0] wr0_data,
  output logic          wr0_ready,
  input  logic          wr1_valid,
  input  logic [AW-1:0] wr1_addr,
  input  logic [DW-1:0] wr1_data,
  output logic          wr1_ready,
`ifdef VMEM_ARB_STATS_EN
  output logic [15:0]   wr_stall_cnt,
`endif
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [AW-1:0] fifo_addr [2][FIFO_DEPTH];
  logic [DW-1:0] fifo_data [2][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr    [2];
  logic [PW-1:0] rd_ptr    [2];
  logic [CW-1:0] count     [2];
  logic [AW-1:0] in_addr   [2];
  logic [DW-1:0] in_data   [2];
  logic [1:0]    in_valid;
  logic [1:0]    full;
  logic [1:0]    not_empty;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic          rr_ptr;
  logic          grant;
  logic          issue_wr;
  logic          rd_pipe;

  // FIFO status, push qualification and the read-first / round-robin issue decision
  always_comb begin
    in_valid   = {wr1_valid, wr0_valid};
    in_addr[0] = wr0_addr;
    in_addr[1] = wr1_addr;
    in_data[0] = wr0_data;
    in_data[1] = wr1_data;
    full       = '0;
    not_empty  = '0;
    push       = '0;
    for (int i = 0; i < 2; i++) begin
      full[i]      = (count[i] == FULL_CNT);
      not_empty[i] = (count[i] != '0);
      // fullness comes from the registered count only, so a same-cycle pop never frees a slot early
      push[i]      = in_valid[i] && !full[i];
    end
    issue_wr = !vga_rd_en && (not_empty != 2'b00);
    if (rr_ptr) grant = not_empty[1] ? 1'b1 : 1'b0;
    else        grant = not_empty[0] ? 1'b0 : 1'b1;
    pop = '0;
    if (issue_wr) pop[grant] = 1'b1;
  end

  assign wr0_ready   = !full[0];
  assign wr1_ready   = !full[1];
  assign vga_rd_data = mem_rdata;

  // Write-entry storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        fifo_addr[i][wr_ptr[i]] <= in_addr[i];
        fifo_data[i][wr_ptr[i]] <= in_data[i];
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end else begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // Registered memory command; the round-robin pointer moves to the loser after each write grant
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr_ptr    <= 1'b0;
    end else if (vga_rd_en) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= vga_rd_addr;
    end else if (issue_wr) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= fifo_addr[grant][rd_ptr[grant]];
      mem_wdata <= fifo_data[grant][rd_ptr[grant]];
      rr_ptr    <= ~grant;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // Two-stage valid shift matching the command register plus the memory's read register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe    <= 1'b0;
      vga_rd_vld <= 1'b0;
    end else begin
      rd_pipe    <= vga_rd_en;
      vga_rd_vld <= rd_pipe;
    end
  end

`ifdef VMEM_ARB_STATS_EN
  // Saturating count of cycles where pending writes are held off by a VGA read
  always_ff @(posedge clk) begin
    if (rst) wr_stall_cnt <= '0;
    else if (vga_rd_en && (not_empty != 2'b00) && (wr_stall_cnt != 16'hFFFF))
      wr_stall_cnt <= wr_stall_cnt + 16'd1;
  end
`endif

endmodule
